// File: rtl/shuffle3_transpose.sv
// shuffle3_transpose
//
// Collects consecutive accepted input rows into 3x3 blocks of 32-bit samples
// and plays each block back transposed: output row k carries column k of the
// block. Two 9-word banks are used ping-pong so one block can be written
// while the previous one is read out. All state moves on the falling edge.
//
// Ports:
//   clk        clock; state updates on the falling edge
//   rst_n      asynchronous active-low reset
//   sync       block-alignment strobe (only when SHUF3_SYNC_EN is defined)
//   in_valid   a/b/c carry one valid input row this cycle
//   a, b, c    input row, lanes 0/1/2, packed {re[31:16], im[15:0]}
//   out_valid  x/y/z carry one valid output row this cycle
//   x, y, z    output row, lanes 0/1/2; forced to 0 when out_valid is low
//
// Optional feature macro: SHUF3_SYNC_EN adds the sync input, which restarts
// the row counter so the current edge's row becomes row 0 of a new block.

module shuffle3_transpose (
    input  logic        clk,
    input  logic        rst_n,
`ifdef SHUF3_SYNC_EN
    input  logic        sync,
`endif
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    output logic        out_valid,
    output logic [31:0] x,
    output logic [31:0] y,
    output logic [31:0] z
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OUT0 = 2'd1,
        OUT1 = 2'd2,
        OUT2 = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  row_cnt_q, row_cnt_d;
    logic        wr_bank_q, wr_bank_d;
    logic        rd_bank_q, rd_bank_d;
    logic        pending_q, pending_d;
    logic [31:0] bank_q [2][9];
    logic [31:0] bank_d [2][9];

    logic        sync_hit;
    logic [1:0]  wr_row;
    logic [3:0]  wr_base;
    logic        block_done;
    logic        start_read;
    logic [3:0]  rd_col;

`ifdef SHUF3_SYNC_EN
    assign sync_hit = sync;
`else
    assign sync_hit = 1'b0;
`endif

    // Write side: a sync strobe makes this edge's row land as row 0, otherwise
    // the running row counter picks the row. Completing row 2 flips the write
    // bank and leaves a pending flag for the read side.
    always_comb begin
        wr_row     = sync_hit ? 2'd0 : row_cnt_q;
        block_done = in_valid && (wr_row == 2'd2);

        case (wr_row)
            2'd0:    wr_base = 4'd0;
            2'd1:    wr_base = 4'd3;
            default: wr_base = 4'd6;
        endcase

        row_cnt_d = row_cnt_q;
        if (in_valid) begin
            row_cnt_d = (wr_row == 2'd2) ? 2'd0 : wr_row + 2'd1;
        end else if (sync_hit) begin
            row_cnt_d = 2'd0;
        end

        wr_bank_d = wr_bank_q ^ block_done;

        bank_d = bank_q;
        if (in_valid) begin
            bank_d[wr_bank_q][wr_base]        = a;
            bank_d[wr_bank_q][wr_base + 4'd1] = b;
            bank_d[wr_bank_q][wr_base + 4'd2] = c;
        end
    end

    // Read FSM: a completed block is noticed one edge after its last row, so
    // output row 0 lags the row-2 capture by one clock. OUT2 chains straight
    // into OUT0 when another block finished meanwhile, giving no bubble.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pending_q) state_d = OUT0;
            OUT0:    state_d = OUT1;
            OUT1:    state_d = OUT2;
            OUT2:    state_d = pending_q ? OUT0 : IDLE;
            default: state_d = IDLE;
        endcase

        start_read = (state_d == OUT0) && ((state_q == IDLE) || (state_q == OUT2));

        // The bank just completed is the one the writer has moved away from.
        rd_bank_d = start_read ? ~wr_bank_q : rd_bank_q;
        pending_d = block_done || (pending_q && !start_read);
    end

    // Output lanes index column k of the read bank; everything reads as zero
    // outside the three output cycles.
    always_comb begin
        out_valid = (state_q != IDLE);
        rd_col    = 4'd0;
        x         = '0;
        y         = '0;
        z         = '0;
        case (state_q)
            OUT1:    rd_col = 4'd1;
            OUT2:    rd_col = 4'd2;
            default: rd_col = 4'd0;
        endcase
        if (out_valid) begin
            x = bank_q[rd_bank_q][rd_col];
            y = bank_q[rd_bank_q][rd_col + 4'd3];
            z = bank_q[rd_bank_q][rd_col + 4'd6];
        end
    end

    // Control state register; reset throws away partial and pending blocks.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            row_cnt_q <= 2'd0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            pending_q <= pending_d;
        end
    end

    // Sample storage carries no reset; stale contents are never presented
    // because out_valid gates the lanes.
    always_ff @(negedge clk) begin
        bank_q <= bank_d;
    end

endmodule

// File: doc/shuffle3_transpose.md
SHUFFLE3_TRANSPOSE -- requirements
Module: shuffle3_transpose

Interface
REQ-001 The block SHALL have no parameters: three lanes of 32 bits each and a 3x3 block size.
REQ-002 clk  input  1  Single clock; all state updates on the falling edge.
REQ-003 rst_n  input  1  Reset; asynchronous, active-low.
REQ-004 in_valid  input  1  Lanes a/b/c carry one valid input row this cycle.
REQ-005 a, b, c  input  32 each  Input row, lanes 0/1/2, sample packed {re[31:16], im[15:0]}.
REQ-006 out_valid  output  1  Lanes x/y/z carry one valid output row this cycle.
REQ-007 x, y, z  output  32 each  Output row, lanes 0/1/2.
REQ-008 sync  input  1  Block-alignment strobe; present only with SHUF3_SYNC_EN.

Function
REQ-009 The block SHALL group consecutive accepted input rows into 3x3 blocks.
REQ-010 Input row r (r = 0,1,2) of a block SHALL be stored as M[r][0..2] = {a,b,c}.
REQ-011 Output row k SHALL be x=M[0][k], y=M[1][k], z=M[2][k], i.e. the transpose.
REQ-012 A row SHALL be accepted only on a falling edge with in_valid=1.
REQ-013 Input gaps (in_valid=0) SHALL neither advance nor disturb the row counter.
REQ-014 Samples SHALL pass bit-exact, with no arithmetic or reordering of re/im.
REQ-015 Storage SHALL be two 9-word banks (ping-pong); the write bank SHALL toggle on the edge that accepts row 2.
REQ-016 Read timing SHALL be as follows.
- Output row 0 appears on the first falling edge after the row-2 capture edge.
- Rows 1 and 2 appear on the next two edges.
- out_valid is high for exactly those 3 cycles, independent of in_valid.
REQ-017 Latency SHALL be 1 clock from the row-2 capture edge to output row 0.
- Back-to-back blocks produce continuous out_valid with no bubble.
REQ-018 x, y and z SHALL be driven to 0 whenever out_valid=0.
REQ-019 The read state machine SHALL have states IDLE, OUT0, OUT1, OUT2.
- IDLE->OUT0 when a block completes.
- OUT0->OUT1->OUT2 unconditionally.
- OUT2->OUT0 if another block completed during OUT0..OUT2, else OUT2->IDLE.
REQ-020 A bank SHALL never be overwritten while it is being read.
- This is guaranteed because input needs at least 3 cycles per block and output takes exactly 3.
REQ-021 The row counter SHALL wrap 2->0 on block completion.

Reset
REQ-022 While rst_n=0 the block SHALL hold the following values.
- Row counter 0, write bank 0, state IDLE.
- out_valid=0 and x=y=z=0.
REQ-023 Assertion of rst_n mid-operation SHALL immediately discard partial and pending blocks and drive the REQ-022 values.
REQ-024 Bank contents need no reset.
REQ-025 The first accepted row after rst_n deasserts SHALL be row 0.

Configuration
REQ-026 With SHUF3_SYNC_EN defined, the sync port SHALL exist with the following behaviour.
- sync=1 on an edge forces the row counter to 0, discarding any partial block.
- If in_valid=1 on that edge, the row is accepted as row 0 of a new block.
- A block that has already completed still outputs normally.
REQ-027 Without SHUF3_SYNC_EN, the sync port SHALL be absent and alignment SHALL be set only by reset.

Verification
REQ-028 Single block: rows {1,2,3},{4,5,6},{7,8,9} with in_valid=1 for 3 cycles -> one cycle later x/y/z = {1,4,7},{2,5,8},{3,6,9} with out_valid=1 for 3 cycles, then 0.
REQ-029 Continuous stream of 4 blocks with values 0..35 -> out_valid high for 12 consecutive cycles, each block transposed, no bubble.
REQ-030 Gapped input: in_valid pattern 1,0,0,1,0,1 with rows {1,2,3},{4,5,6},{7,8,9} -> same transpose as REQ-028, starting 1 cycle after the last valid row.
REQ-031 Reset mid-output: rst_n low during OUT1 -> out_valid=0 and x=y=z=0 immediately; after release the next 3 rows form a fresh block.
REQ-032 Sign/packing: input 32'h8000_7FFF in all nine positions -> same value on every output word.
REQ-033 With SHUF3_SYNC_EN: two rows, then sync=1 with in_valid=1 and row {A,B,C} plus two more rows -> output transposes the new block only; first row out is {A,..,..}.
